// File: rtl/handshake_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module   : handshake_arbiter_pkg
// Purpose  : Shared types and constants for the 4-phase handshake arbiter.
//            Holds the FSM state encoding, the default requester count and
//            watchdog limit, and the watchdog counter width helper.
// Revision : 1.0  initial release
//============================================================================
package handshake_arbiter_pkg;

  localparam int unsigned DEFAULT_N       = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for any request
    S_FWD  = 2'd1,  // request forwarded downstream, awaiting next_ack=1
    S_HOLD = 2'd2,  // ack given to owner, awaiting owner request drop
    S_RTZ  = 2'd3   // downstream request dropped, awaiting next_ack=0
  } state_t;

  // Watchdog counter width: enough bits to count 0 .. timeout-1.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    cnt_width = (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_arbiter_rr_pick.sv
`default_nettype none
//============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set
//            request bit at or above i_ptr (wrapping) as a one-hot vector.
// Ports    : i_request [N]  request vector
//            i_ptr     [PW] search start index (0..N-1)
//            o_winner  [N]  one-hot winner, zero when no request
//            o_valid        at least one request is set
// Revision : 1.0  initial release
//============================================================================
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  i_request,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_winner,
  output logic          o_valid
);

  localparam logic [PW:0] c_N_VAL = (PW+1)'(N);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < int'(N); k++) begin
      // ptr + k never exceeds 2N-2, so one conditional subtract wraps it.
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= c_N_VAL) begin
        w_sum = w_sum - c_N_VAL;
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_request[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

  assign o_valid = |i_request;

endmodule
`default_nettype wire

// File: rtl/handshake_arbiter.sv
`default_nettype none
//============================================================================
// Module   : handshake_arbiter
// Purpose  : Shares one downstream 4-phase request/ack channel among N
//            requesters with round-robin fairness. The FSM walks
//            IDLE -> FWD -> HOLD -> RTZ -> IDLE; all outputs are registered.
// Ports    : clk, reset     clock, synchronous active-high reset
//            request [N]    per-requester 4-phase request
//            ack     [N]    per-requester acknowledge (at most one high)
//            next_request   request to downstream stage
//            next_ack       acknowledge from downstream stage
//            grant   [N]    one-hot channel owner, zero when idle
//            timeout_err    one-cycle pulse on watchdog abort
// Options  : HANDSHAKE_ARB_TIMEOUT_EN  enables the FWD/RTZ watchdog; when
//            undefined the FSM waits indefinitely and timeout_err is 0.
// Revision : 1.0  initial release
//============================================================================
module handshake_arbiter
  import handshake_arbiter_pkg::*;
#(
  parameter int unsigned N       = DEFAULT_N,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] request,
  output logic [N-1:0] ack,
  output logic         next_request,
  input  logic         next_ack,
  output logic [N-1:0] grant,
  output logic         timeout_err
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] c_LAST_IDX = PW'(N - 1);

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [N-1:0]  r_grant;
  logic [N-1:0]  r_ack;
  logic          r_next_request;

  logic [N-1:0]  w_winner;
  logic          w_valid;
  logic [PW-1:0] w_owner_idx;
  logic [PW-1:0] w_ptr_next;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .i_request (request),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_valid   (w_valid)
  );

  // Encode the current owner so the pointer can move just past it.
  always_comb begin
    w_owner_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r_grant[i]) begin
        w_owner_idx = PW'(i);
      end
    end
  end

  assign w_ptr_next = (w_owner_idx == c_LAST_IDX) ? '0 : w_owner_idx + PW'(1);

`ifdef HANDSHAKE_ARB_TIMEOUT_EN
  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;
  logic          w_expired;

  assign w_expired = (r_cnt == c_CNT_LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_grant        <= '0;
      r_ack          <= '0;
      r_next_request <= 1'b0;
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
      r_cnt          <= '0;
      r_timeout_err  <= 1'b0;
`endif
    end else begin
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_grant        <= w_winner;
            r_next_request <= 1'b1;
            r_state        <= S_FWD;
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
            r_cnt          <= '0;
`endif
          end
        end

        // Owner's request level is deliberately not looked at here: a drop
        // during FWD is ignored and the handshake runs to completion.
        S_FWD: begin
          if (next_ack) begin
            r_ack   <= r_grant;
            r_state <= S_HOLD;
          end
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
          else if (w_expired) begin
            r_state        <= S_IDLE;
            r_next_request <= 1'b0;
            r_grant        <= '0;
            r_ack          <= '0;
            r_ptr          <= w_ptr_next;
            r_timeout_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end

        S_HOLD: begin
          if ((request & r_grant) == '0) begin
            r_next_request <= 1'b0;
            r_state        <= S_RTZ;
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
            r_cnt          <= '0;
`endif
          end
        end

        S_RTZ: begin
          if (!next_ack) begin
            r_ack   <= '0;
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_state <= S_IDLE;
          end
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
          else if (w_expired) begin
            r_state        <= S_IDLE;
            r_next_request <= 1'b0;
            r_grant        <= '0;
            r_ack          <= '0;
            r_ptr          <= w_ptr_next;
            r_timeout_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack          = r_ack;
  assign grant        = r_grant;
  assign next_request = r_next_request;

`ifdef HANDSHAKE_ARB_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_handshake_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_handshake_arbiter
// Purpose  : Self-checking bench for handshake_arbiter (N=4, TIMEOUT=16).
//            Per-cycle vectors hold inputs and the outputs expected after
//            the following rising edge; expectations go through a queue.
// Revision : 1.0  initial release
//============================================================================
module tb_handshake_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] request = '0;
  logic         next_ack = 1'b0;
  logic [N-1:0] ack;
  logic         next_request;
  logic [N-1:0] grant;
  logic         timeout_err;

  handshake_arbiter #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .request      (request),
    .ack          (ack),
    .next_request (next_request),
    .next_ack     (next_ack),
    .grant        (grant),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       nack;
    logic [3:0] g;
    logic [3:0] a;
    logic       n;
    logic       t;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [3:0] a;
    logic       n;
    logic       t;
    int         id;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vid   = 0;

  task automatic add(input logic rst, input logic [3:0] req, input logic nack,
                     input logic [3:0] g, input logic [3:0] a,
                     input logic n, input logic t);
    vec_t v;
    v.rst = rst; v.req = req; v.nack = nack;
    v.g = g; v.a = a; v.n = n; v.t = t;
    tbl.push_back(v);
  endtask

  task automatic check();
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: no expectation queued, got grant=%b ack=%b", grant, ack);
      return;
    end
    e = exp_q.pop_front();
    if (grant !== e.g || ack !== e.a || next_request !== e.n || timeout_err !== e.t) begin
      n_err++;
      $display("FAIL vec%0d: got grant=%b ack=%b next_request=%b timeout_err=%b, required grant=%b ack=%b next_request=%b timeout_err=%b",
               e.id, grant, ack, next_request, timeout_err, e.g, e.a, e.n, e.t);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset    = v.rst;
    request  = v.req;
    next_ack = v.nack;
    e.g = v.g; e.a = v.a; e.n = v.n; e.t = v.t; e.id = vid;
    vid++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic run(input logic rst, input logic [3:0] req, input logic nack,
                     input logic [3:0] g, input logic [3:0] a,
                     input logic n, input logic t);
    vec_t v;
    v.rst = rst; v.req = req; v.nack = nack;
    v.g = g; v.a = a; v.n = n; v.t = t;
    apply(v);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] one;
    logic [3:0] all;
    logic [3:0] w;
    one = 4'b0001;
    all = 4'b1111;

    // Reset state
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);

    // Single requester 0, downstream acks after two cycles, full RTZ
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 1, 0);
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 1, 0);
    add(0, 4'b0001, 1, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b0000, 1, 4'b0001, 4'b0001, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
    // pointer is now 1: all requesting picks requester 1
    add(0, 4'b1111, 0, 4'b0010, 4'b0000, 1, 0);
    add(0, 4'b1111, 1, 4'b0010, 4'b0010, 1, 0);
    add(0, 4'b1101, 1, 4'b0010, 4'b0010, 0, 0);
    add(0, 4'b1101, 0, 4'b0000, 4'b0000, 0, 0);

    // Round robin from pointer 0 across all four and back to 0
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
    for (int k = 0; k < 5; k++) begin
      w = one << (k % 4);
      add(0, all,      0, w,       4'b0000, 1, 0);
      add(0, all,      1, w,       w,       1, 0);
      add(0, all & ~w, 1, w,       w,       0, 0);
      add(0, all & ~w, 0, 4'b0000, 4'b0000, 0, 0);
    end

    // Request 2 rises while owner 0 is in HOLD; no effect until RTZ ends
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0001, 0, 4'b0001, 4'b0000, 1, 0);
    add(0, 4'b0001, 1, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b0101, 1, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b0100, 1, 4'b0001, 4'b0001, 0, 0);
    add(0, 4'b0100, 1, 4'b0001, 4'b0001, 0, 0);
    add(0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 4'b0000, 1, 0);
    // owner drops its request during FWD: ignored, handshake completes
    add(0, 4'b0000, 0, 4'b0100, 4'b0000, 1, 0);
    add(0, 4'b0000, 1, 4'b0100, 4'b0100, 1, 0);
    add(0, 4'b0000, 1, 4'b0100, 4'b0100, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);

    // Reset in HOLD abandons transfer; pointer returns to 0
    add(0, 4'b1000, 0, 4'b1000, 4'b0000, 1, 0);
    add(0, 4'b1000, 1, 4'b1000, 4'b1000, 1, 0);
    add(1, 4'b1000, 1, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b1001, 1, 4'b0001, 4'b0000, 1, 0);
    add(0, 4'b1001, 1, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b1000, 1, 4'b0001, 4'b0001, 0, 0);
    add(0, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Downstream never acks: pointer is 1, requesters 0..2 active
    run(0, 4'b0111, 0, 4'b0010, 4'b0000, 1, 0);
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
    for (int c = 1; c < int'(TIMEOUT); c++) begin
      run(0, 4'b0111, 0, 4'b0010, 4'b0000, 1, 0);
    end
    run(0, 4'b0111, 0, 4'b0000, 4'b0000, 0, 1);
    run(0, 4'b0111, 0, 4'b0100, 4'b0000, 1, 0);
    run(0, 4'b0111, 0, 4'b0100, 4'b0000, 1, 0);
`else
    for (int c = 0; c < 24; c++) begin
      run(0, 4'b0111, 0, 4'b0010, 4'b0000, 1, 0);
    end
`endif

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one downstream 4-phase channel (2..8).
REQ-002 Parameter TIMEOUT, default 16: watchdog limit in clk cycles (used only per REQ-021).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 request  input  N  per-requester 4-phase request.
REQ-006 ack  output  N  per-requester acknowledge, at most one bit high.
REQ-007 next_request  output  1  request to shared downstream stage.
REQ-008 next_ack  input  1  acknowledge from downstream stage.
REQ-009 grant  output  N  one-hot owner of channel, all-zero when idle.
REQ-010 timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-011 The FSM SHALL have states IDLE, FWD, HOLD, RTZ; all outputs SHALL be registered.
REQ-012 IDLE: if request != 0, the winner SHALL be the first set bit searching from index ptr upward with wrap; next edge -> FWD, grant = onehot(winner), next_request = 1 (1-cycle latency).
REQ-013 FWD: on next_ack = 1, ack[winner] SHALL go 1 on the next edge -> HOLD; next_request stays 1.
REQ-014 HOLD: on request[winner] = 0, next_request SHALL go 0 on the next edge -> RTZ.
REQ-015 RTZ: on next_ack = 0, ack[winner] and grant SHALL go 0, ptr SHALL become (winner+1) mod N -> IDLE.
REQ-016 Requests are sampled only in IDLE; new or dropped requests from non-owners SHALL not affect the active handshake.
REQ-017 request[winner] dropping during FWD SHALL be ignored; the handshake completes normally.
REQ-018 Minimum cycle time SHALL be 4 clk cycles per transfer; IDLE lasts at least 1 cycle between grants.
REQ-019 ptr wrap: winner N-1 SHALL set ptr to 0.

Reset
REQ-020 With reset = 1 at a rising edge, regardless of state, next edge: state IDLE, ptr 0, counter 0, and ack, grant, next_request, timeout_err all 0; reset mid-handshake SHALL abandon the transfer with no ack pulse.

Configuration
REQ-021 Macro HANDSHAKE_ARB_TIMEOUT_EN defined: a counter SHALL run in FWD and RTZ, clearing on entry to each. Reaching TIMEOUT-1 without the awaited next_ack level SHALL force, on the next edge: IDLE, next_request 0, grant 0, ack 0, ptr advanced past winner, timeout_err 1 for exactly one cycle.
REQ-022 Macro undefined: no counter logic; timeout_err SHALL be tied 0; FSM waits indefinitely.

Structure
REQ-023 Package handshake_arbiter_pkg SHALL hold the state enum, default N/TIMEOUT constants, and the counter-width function (clog2 of TIMEOUT).
REQ-024 One sub-module rr_pick (combinational: request, ptr -> one-hot winner, valid) SHALL be instantiated once; all sequential logic SHALL stay in handshake_arbiter.

Verification
REQ-025 Reset, then request=0001, downstream acks after 2 cycles -> grant=0001 1 cycle later; ack[0] rises 1 cycle after next_ack; full return-to-zero; ptr=1.
REQ-026 request=1111 held, 4 transfers -> grant order 0001,0010,0100,1000, then 0001 again (wrap).
REQ-027 request[2] rises while owner 0 is in HOLD -> no change to ack/grant until RTZ completes; next grant = 0100.
REQ-028 reset pulsed 1 cycle while in HOLD -> all outputs 0 next edge, ptr=0, no ack on any requester.
REQ-029 HANDSHAKE_ARB_TIMEOUT_EN, TIMEOUT=16, next_ack held 0 -> abort at cycle 16 of FWD, timeout_err one pulse, next grant goes to next requester.
REQ-030 Macro undefined, same stimulus -> FSM stays in FWD indefinitely, timeout_err=0 throughout.
